// File: rtl/icache.sv
// Direct-mapped read-only instruction cache (8 x 16-byte blocks); hits return in the same cycle,
// misses stall the CPU on busywait for 3 clocks plus the memory busy time.
module icache (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [9:0]   address,
    output logic [31:0]  instruction,
    output logic         busywait,
    output logic         mem_read,
    output logic [5:0]   mem_address,
    input  logic [127:0] mem_readinst,
    input  logic         mem_busywait
);

    typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

    state_t         state_q;
    logic [7:0]     valid_q;
    logic [2:0]     tag_q  [8];
    logic [127:0]   data_q [8];
    logic [5:0]     miss_addr_q;
    logic [127:0]   fill_buf_q;
    logic           mem_read_q;

    logic [2:0]     addr_tag;
    logic [2:0]     addr_idx;
    logic [1:0]     addr_off;
    logic           hit;
    logic [31:0]    word_sel;
    logic           unused_byte_bits;

    assign addr_tag         = address[9:7];
    assign addr_idx         = address[6:4];
    assign addr_off         = address[3:2];
    assign unused_byte_bits = ^address[1:0];

    assign hit      = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    assign word_sel = data_q[addr_idx][{addr_off, 5'd0} +: 32];

    // Only a settled IDLE hit releases the CPU; fill states always stall.
    assign busywait    = RESET ? 1'b0  : ((state_q != IDLE) || !hit);
    assign instruction = RESET ? 32'd0 : word_sel;
    assign mem_read    = mem_read_q;
    assign mem_address = miss_addr_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            valid_q     <= 8'd0;
            miss_addr_q <= 6'd0;
            fill_buf_q  <= 128'd0;
            mem_read_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!hit) begin
                        miss_addr_q <= {addr_tag, addr_idx};
                        mem_read_q  <= 1'b1;
                        state_q     <= MEM_READ;
                    end
                end
                MEM_READ: begin
                    if (!mem_busywait) begin
                        fill_buf_q <= mem_readinst;
                        mem_read_q <= 1'b0;
                        state_q    <= UPDATE;
                    end
                end
                UPDATE: begin
                    // Fill target comes from the latched miss, not the live address.
                    data_q[miss_addr_q[2:0]]  <= fill_buf_q;
                    tag_q[miss_addr_q[2:0]]   <= miss_addr_q[5:3];
                    valid_q[miss_addr_q[2:0]] <= 1'b1;
                    state_q                   <= IDLE;
                end
                default: begin
                    mem_read_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache with a simple block memory model of configurable busy time.
module tb_icache;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [9:0]   address;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readinst;
    logic         mem_busywait;

    int n_tests = 0;
    int n_fail  = 0;
    int mem_cnt = 0;
    int mem_lat = 5;
    int rd_seen = 0;

    icache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .address      (address),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readinst (mem_readinst),
        .mem_busywait (mem_busywait)
    );

    always #5 CLK = ~CLK;

    // Word w of block a is (a << 24) + w * 0x11111111.
    function automatic logic [127:0] blk_data(input logic [5:0] a);
        logic [127:0] d;
        for (int w = 0; w < 4; w++)
            d[w*32 +: 32] = {2'b00, a, 24'h0} + 32'h11111111 * w;
        return d;
    endfunction

    // Memory raises busy after first seeing mem_read, holds it for mem_lat edges, then returns data.
    always @(negedge CLK) begin
        if (mem_read) begin
            if (mem_cnt < mem_lat) begin
                mem_busywait = 1'b1;
                mem_cnt      = mem_cnt + 1;
            end else begin
                mem_busywait = 1'b0;
                mem_readinst = blk_data(mem_address);
            end
        end else begin
            mem_busywait = 1'b0;
            mem_cnt      = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Counts edges until busywait drops (bounded), plus edges already spent on this miss.
    task automatic wait_fill(input string tag, input int done, input int exp_edges);
        int n = 0;
        rd_seen = 0;
        while (busywait && n < 40) begin
            tick();
            n++;
            if (mem_read) rd_seen++;
        end
        check(tag, 32'(done + n), 32'(exp_edges));
    endtask

    initial begin
        RESET        = 1'b1;
        address      = 10'h000;
        mem_busywait = 1'b0;
        mem_readinst = 128'd0;

        // Reset
        tick();
        tick();
        check("rst_busy",  {31'd0, busywait}, 32'd0);
        check("rst_instr", instruction, 32'h0);
        check("rst_rd",    {31'd0, mem_read}, 32'd0);
        RESET = 1'b0;
        #1;
        check("cold_busy", {31'd0, busywait}, 32'd1);
        check("cold_rd0",  {31'd0, mem_read}, 32'd0);

        // Cold miss
        tick();
        check("cold_rd1",   {31'd0, mem_read}, 32'd1);
        check("cold_maddr", {26'd0, mem_address}, 32'h00);
        wait_fill("cold_lat", 1, 8);
        check("cold_rdlen", 32'(rd_seen), 32'd5);
        check("cold_instr", instruction, 32'h00000000);

        // Hits
        address = 10'h004;
        #1;
        check("hit1_busy",  {31'd0, busywait}, 32'd0);
        check("hit1_instr", instruction, 32'h11111111);
        address = 10'h00C;
        #1;
        check("hit3_instr", instruction, 32'h33333333);
        tick();
        check("hit_rd",     {31'd0, mem_read}, 32'd0);
        check("hit3_busy",  {31'd0, busywait}, 32'd0);

        // Conflict on index 0
        address = 10'h080;
        #1;
        check("conf_busy",  {31'd0, busywait}, 32'd1);
        tick();
        check("conf_maddr", {26'd0, mem_address}, 32'h08);
        wait_fill("conf_lat", 1, 8);
        check("conf_instr", instruction, 32'h08000000);
        address = 10'h084;
        #1;
        check("conf_instr1", instruction, 32'h19111111);
        address = 10'h000;
        #1;
        check("evict_busy", {31'd0, busywait}, 32'd1);
        tick();
        check("evict_maddr", {26'd0, mem_address}, 32'h00);
        wait_fill("evict_lat", 1, 8);
        check("evict_instr", instruction, 32'h00000000);

        // Address change mid-miss
        mem_lat = 3;
        address = 10'h010;
        tick();
        check("mid_maddr", {26'd0, mem_address}, 32'h01);
        tick();
        address = 10'h020;
        #1;
        check("mid_hold",  {26'd0, mem_address}, 32'h01);
        check("mid_busy",  {31'd0, busywait}, 32'd1);
        for (int i = 0; i < 40 && mem_read; i++) tick();
        tick();
        check("mid_remiss", {31'd0, busywait}, 32'd1);
        tick();
        check("mid_maddr2", {26'd0, mem_address}, 32'h02);
        check("mid_rd2",    {31'd0, mem_read}, 32'd1);
        wait_fill("mid_lat", 1, 6);
        check("mid_instr2", instruction, 32'h02000000);
        address = 10'h014;
        #1;
        check("mid_blk1_busy",  {31'd0, busywait}, 32'd0);
        check("mid_blk1_instr", instruction, 32'h12111111);

        // Reset during MEM_READ
        mem_lat = 5;
        address = 10'h050;
        tick();
        tick();
        check("rmid_rd", {31'd0, mem_read}, 32'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        #1;
        check("rmid_rd0",  {31'd0, mem_read}, 32'd0);
        check("rmid_miss", {31'd0, busywait}, 32'd1);
        address = 10'h004;
        #1;
        check("rmid_inval", {31'd0, busywait}, 32'd1);
        tick();
        check("rmid_newrd", {31'd0, mem_read}, 32'd1);
        check("rmid_maddr", {26'd0, mem_address}, 32'h00);
        wait_fill("rmid_lat", 1, 8);
        check("rmid_instr", instruction, 32'h11111111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the CPU's fetch path and the block-organised instruction memory. The CPU presents the byte address of the current instruction and receives a 32-bit instruction, stalling on `busywait` during misses. On a miss the cache fetches a 16-byte block (4 instructions) from instruction memory through a read/busywait handshake. It then refills the block and serves the word.

## Interface
Parameters:
- none; geometry is fixed at 8 blocks × 16 bytes over a 1024-byte instruction space.

Ports (CPU side, then memory side):
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `address`  in  10  byte address of the instruction, driven from `PC[9:0]`.
- `instruction`  out  32  fetched instruction.
- `busywait`  out  1  high = instruction not valid; the CPU holds `PC`.
- `mem_read`  out  1  block read request to instruction memory.
- `mem_address`  out  6  block address `{tag, index}`.
- `mem_readinst`  in  128  block data; word 0 in `[31:0]`, word 3 in `[127:96]`.
- `mem_busywait`  in  1  high while memory is servicing the request.

## Operation
Address fields:
- tag = `address[9:7]`
- index = `address[6:4]`
- word offset = `address[3:2]`
- `address[1:0]` is ignored.

Storage:
- per block: `valid` (1 bit), `tag` (3 bits), data (128 bits).
- hit = `valid[index]` and `tag[index] == address tag`.

`instruction` is the data word of `block[index]` selected by the word offset. It is combinational from `address` and the array.

FSM states:
- **IDLE**
  - `busywait` = !hit; `mem_read` = 0.
  - On an edge with a miss and `RESET=0`: latch `{tag, index}` into `miss_addr` and go to MEM_READ.
- **MEM_READ**
  - `mem_read` = 1; `mem_address` = `miss_addr`; `busywait` = 1.
  - On an edge with `mem_busywait=0`: capture `mem_readinst` into `fill_buf` and go to UPDATE.
  - Otherwise stay in MEM_READ.
- **UPDATE**
  - `mem_read` = 0; `busywait` = 1.
  - On the edge: write `fill_buf` into `block[miss_addr index]`, set its `tag` from `miss_addr`, set `valid=1`, and go to IDLE.

Other rules:
- In IDLE, `mem_address` holds its last value; it is don't-care there.
- Fills use `miss_addr`, not the live `address`. A change of `address` during MEM_READ or UPDATE therefore completes the original fill. The result is then re-evaluated in IDLE: hit, or a new miss.
- No writes from the CPU side; the cache has no dirty state.
- Replacement: the indexed block is overwritten unconditionally.

Reset (synchronous), at an edge with `RESET=1`:
- state returns to IDLE and all 8 `valid` bits clear.
- `miss_addr` = 0 and `fill_buf` = 0.
- This applies in any state and aborts an in-flight MEM_READ. `mem_read` falls with the state change, and the returning memory data is discarded.

Outputs while in reset and IDLE:
- `mem_read` = 0.
- `instruction` = 0: it is forced to 0 while `RESET` is high.
- `busywait` = 0 while `RESET` is high; it goes to 1 afterwards on a cold miss.

## Timing
Hits:
- `busywait` = 0 and `instruction` is valid in the same cycle the address is presented.
- Latency is zero clocks.

Misses:
- `busywait` rises combinationally in the cycle the miss address appears.
- MEM_READ is entered on the next edge. Memory is assumed to raise `mem_busywait` by the edge after it first sees `mem_read=1`.
- Penalty = 1 (IDLE→MEM_READ) + N (memory busy cycles) + 1 (MEM_READ→UPDATE) + 1 (UPDATE→IDLE) clocks.
- Data is valid and `busywait` is low in the first IDLE cycle after UPDATE.

Memory handshake:
- `mem_read` stays high continuously from MEM_READ entry until the exit edge.
- `mem_address` is stable throughout.
- `mem_readinst` is sampled only on the edge where `mem_busywait=0` in MEM_READ.

Reset timing:
- `RESET` high on the same edge as a state transition: reset wins.

## Test plan
- **Reset:** `RESET=1` for 2 edges, then address 0x000 → `valid` all 0; `busywait=1` the cycle after reset falls; `mem_read=1` one edge later.
- **Cold miss:** address 0x000; memory busy 5 cycles returning block 0 = `{0x33333333, 0x22222222, 0x11111111, 0x00000000}` → `mem_address=0`; `busywait` low 8 edges after the miss; `instruction=0x00000000`.
- **Hit:** after the fill, address 0x004 then 0x00C → `busywait=0` immediately; `instruction` = 0x11111111, then 0x33333333; `mem_read` never asserts.
- **Conflict:** address 0x080 (tag 1, index 0) → miss with `mem_address=0x08`; after the fill, 0x000 misses again with `mem_address=0x00`.
- **Address change mid-miss:** miss on 0x010; change the address to 0x020 during MEM_READ → block 1 is filled with tag 0; the new address then misses with `mem_address=0x02`.
- **Reset mid-miss:** assert `RESET` for 1 edge during MEM_READ → `mem_read=0` next cycle; `valid[index]` stays 0; late memory data is ignored.
